// File: rtl/adder_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : adder_scheduler
// Purpose  : Sequencing controller for the signed_adder reduction datapath.
//            For each of N output pixels it reads ceil(K/MAX_NUM_ADD) packed
//            words from the input buffer, drives the adder enable/num_kernel,
//            accumulates the partial sums and writes the final sum through a
//            ready-gated output port.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            start, cfg_*          - job request and configuration (IDLE only)
//            busy, done            - job status (done is a one-cycle pulse)
//            ibus_read_req/addr    - input buffer read (data returns next cycle)
//            add_enable/num_kernel - adder control; add_sum is its result
//            obus_write_*          - output write port, accepted on req&ready
// Revision : 1.0 - initial release
// ============================================================================
module adder_scheduler #(
  parameter int MAX_NUM_ADD   = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int OUT_WIDTH     = 16,
  parameter int ADDR_WIDTH    = 10,
  parameter int CNT_WIDTH     = 8,
  parameter int NUM_ADD_WIDTH = $clog2(MAX_NUM_ADD) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_WIDTH-1:0]     cfg_num_kernel,
  input  logic [CNT_WIDTH-1:0]     cfg_num_out,
  input  logic [ADDR_WIDTH-1:0]    cfg_rd_base,
  input  logic [ADDR_WIDTH-1:0]    cfg_wr_base,
  output logic                     busy,
  output logic                     done,
  output logic                     ibus_read_req,
  output logic [ADDR_WIDTH-1:0]    ibus_read_addr,
  output logic                     add_enable,
  output logic [NUM_ADD_WIDTH-1:0] add_num_kernel,
  input  logic [OUT_WIDTH-1:0]     add_sum,
  output logic                     obus_write_req,
  output logic [ADDR_WIDTH-1:0]    obus_write_addr,
  output logic [OUT_WIDTH-1:0]     obus_write_data,
  input  logic                     obus_write_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ACC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0]     C_MAX_CNT = CNT_WIDTH'(MAX_NUM_ADD);
  localparam logic [NUM_ADD_WIDTH-1:0] C_MAX_NK  = NUM_ADD_WIDTH'(MAX_NUM_ADD);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    k_q, k_d;
  logic [CNT_WIDTH-1:0]    n_q, n_d;
  logic [CNT_WIDTH-1:0]    o_q, o_d;
  logic [CNT_WIDTH-1:0]    rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0]   wr_base_q, wr_base_d;
  logic [OUT_WIDTH-1:0]    acc_q, acc_d;

  // Lanes consumed by the current word: the remaining kernel count capped at
  // one full adder word. The last word of an output may be partial.
  logic [NUM_ADD_WIDTH-1:0] w_nk;
  assign w_nk = (rem_q > C_MAX_CNT) ? C_MAX_NK : NUM_ADD_WIDTH'(rem_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      n_q       <= '0;
      o_q       <= '0;
      rem_q     <= '0;
      rd_ptr_q  <= '0;
      wr_base_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      n_q       <= n_d;
      o_q       <= o_d;
      rem_q     <= rem_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_base_q <= wr_base_d;
      acc_q     <= acc_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    n_d             = n_q;
    o_d             = o_q;
    rem_d           = rem_q;
    rd_ptr_d        = rd_ptr_q;
    wr_base_d       = wr_base_q;
    acc_d           = acc_q;
    busy            = 1'b0;
    done            = 1'b0;
    ibus_read_req   = 1'b0;
    ibus_read_addr  = '0;
    add_enable      = 1'b0;
    add_num_kernel  = '0;
    obus_write_req  = 1'b0;
    obus_write_addr = '0;
    obus_write_data = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d       = cfg_num_kernel;
          n_d       = cfg_num_out;
          rd_ptr_d  = cfg_rd_base;
          wr_base_d = cfg_wr_base;
          acc_d     = '0;
          o_d       = '0;
          rem_d     = cfg_num_kernel;
          if ((cfg_num_kernel == '0) || (cfg_num_out == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        busy           = 1'b1;
        ibus_read_req  = 1'b1;
        ibus_read_addr = rd_ptr_q;
        // The read pointer runs continuously across outputs, so word w of
        // output o lands at rd_base + o*W + w without any multiply.
        rd_ptr_d       = rd_ptr_q + 1'b1;
        state_d        = S_ACC;
      end

      S_ACC: begin
        busy           = 1'b1;
        add_enable     = 1'b1;
        add_num_kernel = w_nk;
        acc_d          = acc_q + add_sum;
        rem_d          = rem_q - CNT_WIDTH'(w_nk);
        state_d        = (rem_q > C_MAX_CNT) ? S_READ : S_WRITE;
      end

      S_WRITE: begin
        busy            = 1'b1;
        obus_write_req  = 1'b1;
        obus_write_addr = wr_base_q + ADDR_WIDTH'(o_q);
        obus_write_data = acc_q;
        if (obus_write_ready) begin
          if (o_q == (n_q - 1'b1)) begin
            state_d = S_DONE;
          end else begin
            o_d     = o_q + 1'b1;
            acc_d   = '0;
            rem_d   = k_q;
            state_d = S_READ;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_scheduler
// Purpose  : Self-checking bench for adder_scheduler. Provides an input buffer
//            and signed adder model, a job-level reference model (expected
//            read addresses, lane counts, writes and latency) and a per-cycle
//            compare process.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_scheduler;

  localparam int MAXA = 4;
  localparam int DW   = 8;
  localparam int OW   = 16;
  localparam int AW   = 10;
  localparam int CW   = 8;
  localparam int NW   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] cfg_num_kernel, cfg_num_out;
  logic [AW-1:0] cfg_rd_base, cfg_wr_base;
  logic          busy, done, ibus_read_req, add_enable, obus_write_req;
  logic [AW-1:0] ibus_read_addr, obus_write_addr;
  logic [NW-1:0] add_num_kernel;
  logic [OW-1:0] add_sum, obus_write_data;
  logic          obus_write_ready;

  adder_scheduler #(
    .MAX_NUM_ADD(MAXA), .DATA_WIDTH(DW), .OUT_WIDTH(OW),
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .NUM_ADD_WIDTH(NW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_num_kernel(cfg_num_kernel), .cfg_num_out(cfg_num_out),
    .cfg_rd_base(cfg_rd_base), .cfg_wr_base(cfg_wr_base),
    .busy(busy), .done(done),
    .ibus_read_req(ibus_read_req), .ibus_read_addr(ibus_read_addr),
    .add_enable(add_enable), .add_num_kernel(add_num_kernel),
    .add_sum(add_sum),
    .obus_write_req(obus_write_req), .obus_write_addr(obus_write_addr),
    .obus_write_data(obus_write_data), .obus_write_ready(obus_write_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- input buffer + signed adder model ----------------
  logic [MAXA*DW-1:0] mem [0:(1<<AW)-1];
  logic [MAXA*DW-1:0] rd_word = '0;

  always @(posedge clk) if (ibus_read_req) rd_word <= mem[ibus_read_addr];

  function automatic int word_sum(logic [MAXA*DW-1:0] wd, int nk);
    int s;
    s = 0;
    for (int i = 0; i < MAXA; i++) begin
      byte l;
      l = wd[i*DW +: DW];
      if (i < nk) s += int'(l);
    end
    return s;
  endfunction

  always_comb begin
    add_sum = OW'(word_sum(rd_word, add_enable ? int'(add_num_kernel) : 0));
  end

  function automatic logic [MAXA*DW-1:0] mkw(int a, int b, int c, int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // ---------------- job-level reference model ----------------
  int exp_rd[$], exp_nk[$], exp_wa[$], exp_wd[$];
  int got_ra[$], got_nk[$], got_wd[$];
  int jk, jn, jw, stalls, last_lat;
  int start_cyc;
  bit job_on = 1'b0;

  task automatic build_model(int k, int n, int rb, int wb);
    int w_per;
    exp_rd.delete(); exp_nk.delete(); exp_wa.delete(); exp_wd.delete();
    w_per = (k + MAXA - 1) / MAXA;
    jk = k; jn = n; jw = w_per;
    if (k == 0 || n == 0) return;
    for (int o = 0; o < n; o++) begin
      int acc;
      acc = 0;
      for (int w = 0; w < w_per; w++) begin
        int a, nk;
        a  = (rb + o * w_per + w) % (1 << AW);
        nk = k - w * MAXA;
        if (nk > MAXA) nk = MAXA;
        exp_rd.push_back(a);
        exp_nk.push_back(nk);
        acc += word_sum(mem[a], nk);
      end
      exp_wa.push_back((wb + o) % (1 << AW));
      exp_wd.push_back(int'($signed(OW'(acc))));
    end
  endtask

  // ---------------- ready generator ----------------
  int rdy_mode = 0;   // 0: tied high, 1: random, 2: low for first 5 write cycles
  int wcnt = 0;
  initial obus_write_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (obus_write_req) begin
      case (rdy_mode)
        0:       obus_write_ready = 1'b1;
        1:       obus_write_ready = 1'($urandom % 2);
        default: obus_write_ready = (wcnt >= 5);
      endcase
      wcnt++;
    end else begin
      wcnt = 0;
      obus_write_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom % 2);
    end
  end

  // ---------------- per-cycle compare process ----------------
  bit prev_rd = 1'b0, prev_stall = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_rd = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (!job_on || cyc == start_cyc) begin
        chk("idle_outputs_zero",
            int'({busy, done, ibus_read_req, ibus_read_addr, add_enable,
                  add_num_kernel, obus_write_req, obus_write_addr, obus_write_data} != '0), 0);
      end else begin
        if (ibus_read_req) begin
          got_ra.push_back(int'(ibus_read_addr));
          if (exp_rd.size() == 0) chk("unexpected_read", int'(ibus_read_addr), -1);
          else chk("read_addr", int'(ibus_read_addr), exp_rd.pop_front());
        end
        if (add_enable) begin
          got_nk.push_back(int'(add_num_kernel));
          chk("acc_follows_read", int'(prev_rd), 1);
          if (exp_nk.size() == 0) chk("unexpected_enable", int'(add_num_kernel), -1);
          else chk("num_kernel", int'(add_num_kernel), exp_nk.pop_front());
        end else if (add_num_kernel != '0) begin
          chk("num_kernel_when_disabled", int'(add_num_kernel), 0);
        end
        if (prev_stall) chk("req_held_in_stall", int'(obus_write_req), 1);
        if (obus_write_req) begin
          if (exp_wa.size() == 0) chk("unexpected_write", int'(obus_write_addr), -1);
          else begin
            chk("write_addr", int'(obus_write_addr), exp_wa[0]);
            chk("write_data", int'($signed(obus_write_data)), exp_wd[0]);
            if (obus_write_ready) begin
              void'(exp_wa.pop_front());
              void'(exp_wd.pop_front());
              got_wd.push_back(int'($signed(obus_write_data)));
            end else begin
              stalls++;
            end
          end
        end
        chk("one_strobe_at_a_time",
            int'(ibus_read_req) + int'(add_enable) + int'(obus_write_req) > 1 ? 1 : 0, 0);
        if (done) begin
          last_lat = cyc - start_cyc;
          chk("busy_low_in_done", int'(busy), 0);
          chk("latency", last_lat,
              (jk == 0 || jn == 0) ? 1 : 1 + jn * (2 * jw + 1) + stalls);
          chk("reads_left", exp_rd.size(), 0);
          chk("writes_left", exp_wa.size(), 0);
          job_on = 1'b0;
        end else begin
          chk("busy_in_job", int'(busy), 1);
        end
      end
      prev_rd    = ibus_read_req;
      prev_stall = obus_write_req && !obus_write_ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_cfg(int k, int n, int rb, int wb);
    cfg_num_kernel = CW'(k);
    cfg_num_out    = CW'(n);
    cfg_rd_base    = AW'(rb);
    cfg_wr_base    = AW'(wb);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    job_on = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic kick(int k, int n, int rb, int wb);
    build_model(k, n, rb, wb);
    stalls = 0;
    got_ra.delete(); got_nk.delete(); got_wd.delete();
    @(posedge clk); #1;
    set_cfg(k, n, rb, wb);
    start = 1'b1;
    job_on = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(int k, int n, int rb, int wb, bit poke, bit start_in_done);
    kick(k, n, rb, wb);
    for (int i = 0; i < 3000 && job_on; i++) begin
      if (poke) begin
        set_cfg($urandom_range(1, 20), $urandom_range(1, 5), $urandom % 1024, $urandom % 1024);
        start = ($urandom % 6 == 0);
      end
      if (done && start_in_done) begin
        set_cfg(5, 2, $urandom % 1024, $urandom % 1024);
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (job_on) begin
      chk("job_timeout", 1, 0);
      do_reset();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_cfg(0, 0, 0, 0);
    for (int i = 0; i < (1 << AW); i++) mem[i] = MAXA*DW'($urandom);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Basic sum: {1,2,3,4} -> 10, done in cycle 4.
    mem[16] = mkw(1, 2, 3, 4);
    rdy_mode = 0;
    build_model(4, 1, 16, 5);
    chk("model_basic_sum", exp_wd[0], 10);
    run_job(4, 1, 16, 5, 0, 0);
    chk("basic_write_data", got_wd.size() > 0 ? got_wd[0] : -9999, 10);
    chk("basic_read_addr", got_ra.size() > 0 ? got_ra[0] : -1, 16);
    chk("basic_latency", last_lat, 4);

    // Multi-word, signed, partial final word.
    mem[64] = mkw(-1, -2, -3, -4);
    mem[65] = mkw(5, 6, 99, 99);
    mem[66] = mkw(-128, -128, -128, -128);
    mem[67] = mkw(1, 0, 77, 77);
    build_model(6, 2, 64, 100);
    chk("model_mw_w0", exp_wd[0], 1);
    chk("model_mw_w1", exp_wd[1], -511);
    run_job(6, 2, 64, 100, 0, 1);
    chk("mw_write0", got_wd.size() > 1 ? got_wd[0] : -9999, 1);
    chk("mw_write1", got_wd.size() > 1 ? got_wd[1] : -9999, -511);
    for (int i = 0; i < 4; i++) begin
      int nk_req[4] = '{4, 2, 4, 2};
      chk("mw_nk_seq", got_nk.size() > i ? got_nk[i] : -1, nk_req[i]);
      chk("mw_read_seq", got_ra.size() > i ? got_ra[i] : -1, 64 + i);
    end

    // Backpressure: 5 stall cycles per write.
    rdy_mode = 2;
    run_job(6, 2, 64, 100, 0, 0);
    chk("bp_latency", last_lat, 21);
    chk("bp_write1", got_wd.size() > 1 ? got_wd[1] : -9999, -511);
    rdy_mode = 0;

    // Zero configurations.
    run_job(0, 3, 10, 10, 0, 1);
    chk("zero_k_latency", last_lat, 1);
    chk("zero_k_reads", got_ra.size() + got_wd.size(), 0);
    run_job(5, 0, 10, 10, 0, 0);
    chk("zero_n_latency", last_lat, 1);
    chk("zero_n_reads", got_ra.size() + got_wd.size(), 0);

    // Reset during ACC of the second word, then a fresh job.
    begin
      int seen;
      seen = 0;
      kick(6, 2, 64, 100);
      for (int i = 0; i < 50 && seen < 2; i++) begin
        if (add_enable) seen++;
        if (seen < 2) begin @(posedge clk); #1; end
      end
      chk("reached_second_acc", seen, 2);
      reset = 1'b1;
      job_on = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("outputs_after_reset",
          int'({busy, done, ibus_read_req, add_enable, add_num_kernel,
                obus_write_req, obus_write_addr, obus_write_data} != '0), 0);
      run_job(4, 1, 16, 7, 0, 0);
      chk("post_reset_sum", got_wd.size() > 0 ? got_wd[0] : -9999, 10);
    end

    // Address wrap with spurious starts and cfg churn while busy.
    run_job(8, 1, 1023, 1023, 1, 1);
    chk("wrap_read0", got_ra.size() > 1 ? got_ra[0] : -1, 1023);
    chk("wrap_read1", got_ra.size() > 1 ? got_ra[1] : -1, 0);

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      int k, n;
      k = ($urandom % 6 == 0) ? 0 : $urandom_range(1, 20);
      n = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 5);
      rdy_mode = $urandom % 3;
      run_job(k, n, $urandom % 1024, $urandom % 1024, 1'($urandom % 2), 1'($urandom % 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_scheduler.md
# adder_scheduler

Sequencing controller for the `signed_adder` reduction datapath. It steps through a configured number of output pixels. For each one it reads `ceil(K / MAX_NUM_ADD)` packed words from the input buffer and drives the adder's `enable` and `num_kernel`. It accumulates the partial sums across words and writes each final sum to the output buffer through a ready-gated write port. It sits between the layer-level control FSM and the buffer/adder pair.

## Interface
- `MAX_NUM_ADD`, default 4: lanes per adder word; must match the adder instance.
- `DATA_WIDTH`, default 8: lane width; must match the adder instance.
- `OUT_WIDTH`, default 16: width of the adder sum and the accumulator.
- `ADDR_WIDTH`, default 10: width of the buffer read and write addresses.
- `CNT_WIDTH`, default 8: width of the kernel and output counts.
- `NUM_ADD_WIDTH`, default `$clog2(MAX_NUM_ADD)+1`: width of `add_num_kernel`.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `cfg_num_kernel`  in  CNT_WIDTH  total kernel count K per output; latched on accepted `start`.
- `cfg_num_out`  in  CNT_WIDTH  number of outputs N; latched on accepted `start`.
- `cfg_rd_base`  in  ADDR_WIDTH  first read address; latched on accepted `start`.
- `cfg_wr_base`  in  ADDR_WIDTH  first write address; latched on accepted `start`.
- `busy`  out  1  high in READ, ACC and WRITE.
- `done`  out  1  one-cycle pulse at the end of a job.
- `ibus_read_req`  out  1  buffer read strobe; data is returned the following cycle straight into the adder.
- `ibus_read_addr`  out  ADDR_WIDTH  buffer read address.
- `add_enable`  out  1  adder `enable`.
- `add_num_kernel`  out  NUM_ADD_WIDTH  adder `num_kernel`.
- `add_sum`  in  OUT_WIDTH  adder `obus_write_data`, combinational.
- `obus_write_req`  out  1  output write request.
- `obus_write_addr`  out  ADDR_WIDTH  output write address.
- `obus_write_data`  out  OUT_WIDTH  output write data (the accumulator).
- `obus_write_ready`  in  1  the write is accepted in any cycle where both req and ready are high.

## Operation
- State IDLE:
  - On `start`, latch the config, clear the accumulator, clear the output index `o` and word index `w`, and set `rem = K`.
  - If K==0 or N==0, go to DONE. Otherwise go to READ.
- State READ: assert `ibus_read_req` with `ibus_read_addr = rd_ptr`; go to ACC.
  - `rd_ptr` starts at `cfg_rd_base` and increments by 1 per word, across all outputs continuously.
  - Word address for output `o`, word `w` is `rd_base + o*W + w`, where `W = ceil(K/MAX_NUM_ADD)`.
- State ACC:
  - Assert `add_enable` with `add_num_kernel = min(rem, MAX_NUM_ADD)`.
  - Update `acc <= acc + add_sum` and `rem <= rem - add_num_kernel`.
  - If `rem > MAX_NUM_ADD`, go to READ. Otherwise go to WRITE.
- State WRITE:
  - Assert `obus_write_req` with `obus_write_addr = cfg_wr_base + o` and `obus_write_data = acc`.
  - Hold addr and data stable until ready is high.
  - On acceptance: if `o == N-1`, go to DONE. Otherwise increment `o`, clear acc, set `rem = K`, and go to READ.
- State DONE: `done = 1` for one cycle; go to IDLE.
- Outside their states, `ibus_read_req`, `add_enable` and `obus_write_req` are 0. `add_num_kernel` is 0 when `add_enable` is low.
- Arithmetic:
  - The accumulator is signed OUT_WIDTH and wraps modulo 2^OUT_WIDTH, with no saturation.
  - Addresses wrap modulo 2^ADDR_WIDTH.
- `start` in any state other than IDLE, including DONE, is ignored.
- `cfg_*` changes after acceptance have no effect on the running job.

## Timing
- Reset values: all outputs are 0 and the state is IDLE.
- Reset asserted mid-job: the next cycle shows IDLE with all outputs 0. Any pending write is dropped and the accumulator is cleared.
- Accepted `start` in cycle 0 gives READ in cycle 1, with `busy` and `ibus_read_req` high.
- Per word: 2 cycles (READ, ACC).
- Per output: 2W cycles plus 1 WRITE cycle, plus any stall cycles with ready low.
- Job latency with no stalls: `N*(2W+1) + 1` cycles from `start` to the `done` pulse.
- K==0 or N==0: `done` pulses in cycle 1; no read or write is ever issued.
- `busy` is low in DONE.

## Test plan
- Basic sum: MAX=4, K=4, N=1, word at rd_base=0x10 = lanes {1,2,3,4}, ready tied high.
  - Read of 0x10 in cycle 1; ACC in cycle 2 with num_kernel=4.
  - Write req of data 10 at wr_base in cycle 3; `done` in cycle 4.
- Multi-word, signed, partial lane: K=6, N=2, words {-1,-2,-3,-4}, {5,6,99,99}, {-128,-128,-128,-128}, {1,0,77,77}.
  - num_kernel sequence is 4, 2, 4, 2.
  - Writes are 1 then -511.
  - Read addresses are base+0 through base+3.
- Backpressure: ready held low for 5 cycles in WRITE.
  - req, addr and data stay stable, no read is issued, and the next READ follows acceptance by 1 cycle.
- Zero config: K=0 with N=3 gives a `done` pulse in cycle 1 with no reads or writes. Repeat with N=0 and K=5.
- Reset mid-ACC of the second word, then a new start with K=4.
  - All outputs are 0 the cycle after reset.
  - The new result is independent of the old accumulator.
- Wrap and ignored start:
  - rd_base=2^ADDR_WIDTH-1, K=8: reads 0x3FF then 0x000.
  - A `start` pulse while busy changes nothing.
